// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back stage has priority and
// long-latency results wait in a small in-order buffer that drains on idle cycles.
module wb_port_arbiter #(
    parameter int XLEN       = 64,
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 8,
    localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            lu_valid,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            lu_ready,
    output logic            pipe_stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     pend_mask,
    output logic [CW-1:0]   buf_count
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]           rd_mem   [BUF_DEPTH];
    logic [XLEN-1:0]      data_mem [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [SW-1:0]        starve_q, starve_d;
    logic                 rf_we_q, rf_we_d;
    logic [4:0]           rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;

    logic full, nonempty, pipe_req, push, pop;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic [31:0]     slot_mask [BUF_DEPTH];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count_q == CW'(BUF_DEPTH));
    assign nonempty   = (count_q != '0);
    assign lu_ready   = !full;
    assign pipe_stall = full || (nonempty && starve_q == SW'(STARVE_MAX));
    // A stalled pipeline is holding its write; it is taken once the stall drops.
    assign pipe_req   = pipe_we && (pipe_rd != 5'd0) && !pipe_stall;
    assign push       = lu_valid && lu_ready;
    assign pop        = !pipe_req && nonempty;
    assign head_rd    = rd_mem[head_q];
    assign head_data  = data_mem[head_q];

    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
            assign slot_mask[gi] = valid_q[gi] ? (32'd1 << rd_mem[gi]) : 32'd0;
        end
    endgenerate

    always_comb begin
        pend_mask = 32'd0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            pend_mask = pend_mask | slot_mask[i];
        end
        pend_mask[0] = 1'b0;
    end

    always_comb begin
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        starve_d   = starve_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = next_ptr(head_q);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = next_ptr(tail_q);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (pipe_req) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_rd;
            rf_wdata_d = pipe_data;
        end else if (pop) begin
            // x0 entries still drain through the port, just without a write.
            rf_we_d    = (head_rd != 5'd0);
            rf_waddr_d = head_rd;
            rf_wdata_d = head_data;
        end

        if (pop || !nonempty) begin
            starve_d = '0;
        end else if (pipe_req && starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= '0;
        end else begin
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail_q]   <= lu_rd;
            data_mem[tail_q] <= lu_data;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign buf_count = count_q;
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between the in-order pipeline write-back stage and a long-latency unit (divider / uncached-load return) that produces results out of band. Long-latency results are queued in a small in-order buffer and drained on cycles the pipeline does not write. The block stalls the pipeline when the buffer is full or has been starved too long. It sits between the write-back stage outputs and the register file write port.

## Interface
- `XLEN`, 64, data width
- `BUF_DEPTH`, 2, long-latency result buffer entries (≥2)
- `STARVE_MAX`, 8, consecutive pipeline grants tolerated while buffer non-empty
- `clk` in 1: clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `pipe_we` in 1: pipeline write request (registered WB-stage output)
- `pipe_rd` in 5: pipeline destination register
- `pipe_data` in XLEN: pipeline write data
- `lu_valid` in 1: long-latency result valid
- `lu_rd` in 5: long-latency destination register
- `lu_data` in XLEN: long-latency result
- `lu_ready` out 1: buffer can accept (valid/ready handshake)
- `pipe_stall` out 1: freeze pipeline (drives WB-stage `stall`)
- `rf_we` out 1: register file write enable
- `rf_waddr` out 5: register file write address
- `rf_wdata` out XLEN: register file write data
- `pend_mask` out 32: bit r set if any buffered entry targets rN (bit 0 always 0)
- `buf_count` out $clog2(BUF_DEPTH+1): occupied entries

## Operation
- Buffer: circular FIFO, head/tail pointers wrap modulo `BUF_DEPTH`; push on `lu_valid && lu_ready`; `lu_ready = (buf_count < BUF_DEPTH)`, derived from state only (no combinational path from `lu_valid`).
- Pipeline request effective: `pipe_req = pipe_we && pipe_rd != 0 && !pipe_stall`.
- `pipe_stall = full || (nonempty && starve_cnt == STARVE_MAX)`, derived from state only.
- Grant per cycle, exactly one or none:
  - pipeline if `pipe_req`;
  - else FIFO head if non-empty (pop).
- While `pipe_stall` is asserted, pipeline inputs are ignored (the WB stage holds them), so a held write commits exactly once, after the stall drops.
- Starve counter: increments (saturating at `STARVE_MAX`) on a pipeline grant while FIFO non-empty; clears on any FIFO pop or when FIFO empty.
- Entries with `lu_rd == 0` are accepted and occupy a slot; at drain they pop with `rf_we = 0`.
- Simultaneous push and pop in one cycle: both occur, count unchanged. Push when full is impossible (`lu_ready` = 0). Pop when empty never occurs.
- `pend_mask`: OR of one-hot(rd) over valid entries, excluding rd 0. The issue logic uses it to block writers/readers of pending registers; WAW ordering is not enforced here.

## Timing
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `pend_mask`=0, `buf_count`=0, `pipe_stall`=0, `lu_ready`=1. Pointers and starve counter clear. Reset mid-operation discards all buffered entries next edge.
- `rf_*` registered: grant in cycle t → `rf_we` high in cycle t+1 with the granted rd/data, for one cycle per grant.
- LU push at edge t: entry at head, counted in `buf_count`/`pend_mask`/`lu_ready` from cycle t+1. Earliest pop is cycle t+1 → `rf_we` in t+2.
- `pipe_stall` rises the cycle after the edge that makes the FIFO full or saturates the starve counter. It falls the cycle after the pop that clears the condition.
- Forced-stall sequence: exactly one pop per stall cycle. Stall persists while full.

## Test plan
- Reset: hold `reset` 2 cycles with `lu_valid`=1, `pipe_we`=1 → all outputs at reset values, no `rf_we`, `buf_count`=0 after release.
- Idle pipeline: push rd=5 data=0xAB at cycle 0 → `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xAB at cycle 2; `pend_mask[5]` high in cycle 1 only.
- Full buffer: pipeline writes every cycle (rd=1); push rd=3, then rd=4 → `lu_ready`=0 and `pipe_stall`=1 next cycle. rd=3 commits, then the held pipe write rd=1 commits exactly once after the stall drops.
- Starvation: one entry rd=7 buffered, pipeline writes rd=2 continuously → after 8 pipeline grants `pipe_stall` pulses 1 cycle and rd=7 commits.
- x0 handling: `pipe_we`=1 with `pipe_rd`=0 → no `rf_we`. LU push with rd=0 → `buf_count` 1 then 0, `rf_we` stays 0, `pend_mask`=0.
- Simultaneous: FIFO holds 1 entry, pipeline idle, push in same cycle as pop → `buf_count` stays 1, pointers wrap correctly over 10 back-to-back pushes with in-order commits.
